pix_packer: RTL

Front-end write stage for the frame buffer. It takes a pixel stream (`pix_valid`/`pix_data`, framed by `vsync`) in the `wr_clk` domain and packs `DATA_WIDTH/PIX_WIDTH` pixels into each memory word. Each word is presented to the frame buffer write port with a one-cycle active-low write strobe. The block also pads the final partial word of a frame, holds one word while the buffer is not ready, and flags dropped words.

---
 rtl/pix_packer_pkg.sv | 26 ++
 rtl/pix_packer_word_assembler.sv | 73 +++++++
 rtl/pix_packer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pix_packer_pkg.sv
// ---------------------------------------------------------------------------
// pix_packer_pkg
// Shared definitions for the pixel packer:
//   - FSM state encoding (WAIT_SOF, PACK)
//   - active-low strobe levels (ASSERT_L / DEASSERT_L)
//   - helpers for pixels-per-word and slot-index width
// ---------------------------------------------------------------------------
package pix_packer_pkg;

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] PACK     = 1'b1;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

  // Pixels packed into one frame-buffer word.
  function automatic int calc_ppw(input int data_width, input int pix_width);
    return data_width / pix_width;
  endfunction

  // Width of the slot index; at least one bit even when a word holds one pixel.
  function automatic int calc_idx_w(input int ppw);
    return (ppw > 1) ? $clog2(ppw) : 1;
  endfunction

endpackage

// File: rtl/pix_packer_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects pixels into a DATA_WIDTH word, pixel 0 in the lowest slice.
// The word being built is kept with unfilled slots at zero, so a word closed
// early by the end of a frame is already zero-padded.
// Ports:
//   wr_clk     clock
//   reset      synchronous, active-high
//   restart    discard the partial word; an accompanying pixel goes to slot 0
//   pix_in     accept pix_data this cycle
//   pix_data   pixel value
//   frame_end  the accepted pixel is the last one of the frame
//   word_done  (comb) the accepted pixel completes a word
//   word_data  (comb) the completed word, valid while word_done = 1
// ---------------------------------------------------------------------------
module word_assembler
  import pix_packer_pkg::*;
#(
  parameter int PIX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  pix_in,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  input  logic                  frame_end,
  output logic                  word_done,
  output logic [DATA_WIDTH-1:0] word_data
);

  localparam int PPW   = calc_ppw(DATA_WIDTH, PIX_WIDTH);
  localparam int IDX_W = calc_idx_w(PPW);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(PPW - 1);

  logic [IDX_W-1:0]      slot_q;
  logic [IDX_W-1:0]      slot_eff;
  logic [DATA_WIDTH-1:0] word_q;

  // NOTE: every output of a combinational block gets a value before any
  // conditional update, so no path leaves it unassigned and no latch appears.
  always_comb begin
    slot_eff  = restart ? '0 : slot_q;
    word_data = restart ? '0 : word_q;
    for (int i = 0; i < PPW; i++) begin
      if (slot_eff == IDX_W'(i)) begin
        word_data[i*PIX_WIDTH +: PIX_WIDTH] = pix_data;
      end
    end
    word_done = pix_in && ((slot_eff == LAST_SLOT) || frame_end);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      slot_q <= '0;
      word_q <= '0;
    end else if (pix_in) begin
      if (word_done) begin
        slot_q <= '0;
        word_q <= '0;
      end else begin
        slot_q <= slot_eff + IDX_W'(1);
        word_q <= word_data;
      end
    end else if (restart) begin
      slot_q <= '0;
      word_q <= '0;
    end
  end

endmodule

// File: rtl/pix_packer.sv
// ---------------------------------------------------------------------------
// pix_packer
// Frame-buffer write front end: packs DATA_WIDTH/PIX_WIDTH pixels per word,
// pads the last word of a frame, issues a one-cycle active-low write strobe,
// holds one word while the buffer is busy and flags dropped words.
// Optional statistics counters are enabled by defining PIX_PACKER_STATS_EN.
// Ports:
//   wr_clk      clock
//   reset       synchronous, active-high
//   vsync       start of frame (one cycle)
//   pix_valid   pix_data valid
//   pix_data    pixel
//   buf_ready   frame buffer can accept a write
//   wr_en_out   active-low write strobe, one cycle per word
//   data_out    word to write, held until the next emit
//   frame_done  pulse with the strobe of the frame's final word
//   overflow    sticky, a completed word was dropped
//   frame_cnt   (PIX_PACKER_STATS_EN) saturating count of frame_done pulses
//   drop_cnt    (PIX_PACKER_STATS_EN) saturating count of dropped words
// ---------------------------------------------------------------------------
module pix_packer
  import pix_packer_pkg::*;
#(
  parameter int PIX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_PIX  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  pix_valid,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  input  logic                  buf_ready,
  output logic                  wr_en_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  overflow
`ifdef PIX_PACKER_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_PIX = CNT_WIDTH'(FRAME_PIX - 1);

  logic [0:0]            state_q;
  logic [CNT_WIDTH-1:0]  pix_cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_eff;
  logic                  pend_q;
  logic                  pend_last_q;
  logic [DATA_WIDTH-1:0] pend_data_q;

  logic                  pix_in;
  logic                  frame_end;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_last;
  logic                  emit_pend;
  logic                  emit_direct;
  logic                  drop;
  logic                  to_pend;
  logic                  frame_done_nxt;

  // vsync is honoured in both states, so a pixel alongside it is always
  // pixel 0 of a fresh frame.
  always_comb begin
    cnt_eff     = vsync ? '0 : pix_cnt_q;
    pix_in      = pix_valid && (vsync || (state_q == PACK));
    frame_end   = (cnt_eff == LAST_PIX);
    word_last   = word_done && frame_end;
    // A pending word always goes first; a word completing on the same edge
    // takes over the slot it frees.
    emit_pend   = pend_q && buf_ready;
    emit_direct = word_done && buf_ready && !pend_q;
    drop        = word_done && pend_q && !buf_ready;
    to_pend     = word_done && !emit_direct && !drop;
    // A dropped final word still marks the end of the frame.
    frame_done_nxt = (emit_pend && pend_last_q) || (emit_direct && word_last) ||
                     (drop && word_last);
  end

  word_assembler #(
    .PIX_WIDTH  (PIX_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_assembler (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .restart   (vsync),
    .pix_in    (pix_in),
    .pix_data  (pix_data),
    .frame_end (frame_end),
    .word_done (word_done),
    .word_data (word_data)
  );

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      pix_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      // NOTE: the pending data register is reset as well; it is a single
      // word, not a memory array, and keeps data_out fully deterministic.
      pend_data_q <= '0;
      wr_en_out   <= DEASSERT_L;
      data_out    <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (word_last) begin
        state_q <= WAIT_SOF;
      end else if (vsync) begin
        state_q <= PACK;
      end

      if (word_last) begin
        pix_cnt_q <= '0;
      end else if (pix_in) begin
        pix_cnt_q <= cnt_eff + CNT_WIDTH'(1);
      end else if (vsync) begin
        pix_cnt_q <= '0;
      end

      wr_en_out  <= DEASSERT_L;
      frame_done <= frame_done_nxt;
      if (emit_pend) begin
        wr_en_out <= ASSERT_L;
        data_out  <= pend_data_q;
      end else if (emit_direct) begin
        wr_en_out <= ASSERT_L;
        data_out  <= word_data;
      end

      if (to_pend) begin
        pend_q      <= 1'b1;
        pend_data_q <= word_data;
        pend_last_q <= word_last;
      end else if (emit_pend) begin
        pend_q <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PIX_PACKER_STATS_EN
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_done_nxt && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
